decoder_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 3-to-8 line decoder (inputs x, y, z; one-hot output D[7:0]).
- Steps a 3-bit channel index through 0..last_idx, holding each index for a programmable dwell time, with an optional blanking gap between channels.
- Drives {x,y,z} so the decoder produces a rotating one-hot select for row/digit scanning.
- Supports single-frame and continuous modes, a start/stop handshake, and a frame-complete pulse.

---
 rtl/decoder_scan_pkg.sv | 15 +
 rtl/scan_dwell_timer.sv | 31 +++
 rtl/decoder_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Index and blanking widths are fixed by the 3-to-8 decoder it drives.
package decoder_scan_pkg;

    localparam int IDX_W       = 3;
    localparam int BLANK_W     = 4;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BLANK
    } state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// Up counter with synchronous clear and a terminal-count flag.
// Shared between channel dwell timing and inter-channel blanking.
module scan_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = clear_i ? '0 : cnt_q + W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer feeding {x,y,z} of a 3-to-8 decoder: steps a channel
// index 0..last_idx with programmable dwell and optional blanking.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W   = DWELL_W_DEF,
    parameter int BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               x,
    output logic               y,
    output logic               z,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [DWELL_W-1:0] BLANK_TERM =
        (BLANK_CYC > 0) ? DWELL_W'(BLANK_CYC - 1) : '0;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic               stop_pending_q, stop_pending_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic               tmr_clear;
    logic               tmr_tc;
    logic [DWELL_W-1:0] tmr_term;

    // Terminal count is dwell-1 so the counter never wraps.
    assign tmr_term = (state_q == BLANK) ? BLANK_TERM : dwell_q - DWELL_W'(1);

    scan_dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tmr_clear),
        .term_i  (tmr_term),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        last_d         = last_q;
        dwell_d        = dwell_q;
        cont_d         = cont_q;
        stop_pending_d = stop_pending_q | (busy_q & stop);
        frame_done_d   = 1'b0;
        tmr_clear      = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_clear      = 1'b1;
                stop_pending_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cont_d  = cont;
                    last_d  = last_idx;
                    dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                end
            end
            RUN: begin
                if (tmr_tc) begin
                    tmr_clear = 1'b1;
                    if (idx_q != last_q) begin
                        if (BLANK_CYC > 0) state_d = BLANK;
                        else               idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        frame_done_d = 1'b1;
                        if (!cont_q || stop_pending_q) begin
                            state_d        = IDLE;
                            idx_d          = '0;
                            stop_pending_d = 1'b0;
                        end else if (BLANK_CYC > 0) begin
                            state_d = BLANK;
                        end else begin
                            idx_d = '0;
                        end
                    end
                end
            end
            BLANK: begin
                // Index holds through the gap; advance only on entry to RUN.
                if (tmr_tc) begin
                    tmr_clear = 1'b1;
                    state_d   = RUN;
                    idx_d     = (idx_q == last_q) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_valid_d = (state_d == RUN);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            last_q         <= '0;
            dwell_q        <= '0;
            cont_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            sel_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
            dwell_q        <= dwell_d;
            cont_q         <= cont_d;
            stop_pending_q <= stop_pending_d;
            sel_valid_q    <= sel_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign x          = idx_q[2];
    assign y          = idx_q[1];
    assign z          = idx_q[0];
    assign sel_valid  = sel_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench: three builds (BLANK_CYC = 1, 0, 2) share stimulus and are
// compared each cycle against a timeline model derived from frame arithmetic.
module tb_decoder_scan_ctrl;

    localparam int DW = 16;
    localparam int NM = 3;
    localparam int BLANKS [NM] = '{1, 0, 2};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cont;
    logic          stop;
    logic [DW-1:0] dwell;
    logic [2:0]    last_idx;

    logic [NM-1:0] x_v, y_v, z_v, sv_v, bz_v, fd_v;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop),
        .dwell(dwell), .last_idx(last_idx),
        .x(x_v[0]), .y(y_v[0]), .z(z_v[0]),
        .sel_valid(sv_v[0]), .busy(bz_v[0]), .frame_done(fd_v[0])
    );

    decoder_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(0)) u_dut_b0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop),
        .dwell(dwell), .last_idx(last_idx),
        .x(x_v[1]), .y(y_v[1]), .z(z_v[1]),
        .sel_valid(sv_v[1]), .busy(bz_v[1]), .frame_done(fd_v[1])
    );

    decoder_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(2)) u_dut_b2 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop),
        .dwell(dwell), .last_idx(last_idx),
        .x(x_v[2]), .y(y_v[2]), .z(z_v[2]),
        .sel_valid(sv_v[2]), .busy(bz_v[2]), .frame_done(fd_v[2])
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    // Model: a scan is a timeline t = cycles since the start edge.
    bit m_active [NM];
    bit m_fd     [NM];
    bit m_cont   [NM];
    int m_t      [NM];
    int m_dwell  [NM];
    int m_last   [NM];
    int m_end    [NM];

    int cnt_busy [NM];
    int cnt_fd   [NM];
    int cnt_sel  [NM];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int p, fp, e0, n, kk;
        m_fd[k] = 1'b0;
        if (rst) begin
            m_active[k] = 1'b0;
        end else if (!m_active[k]) begin
            if (start) begin
                m_active[k] = 1'b1;
                m_t[k]      = 0;
                m_cont[k]   = cont;
                m_dwell[k]  = (dwell == '0) ? 1 : int'(dwell);
                m_last[k]   = int'(last_idx);
                p           = m_dwell[k] + BLANKS[k];
                m_end[k]    = cont ? -1 : m_last[k] * p + m_dwell[k];
            end
        end else begin
            p  = m_dwell[k] + BLANKS[k];
            fp = (m_last[k] + 1) * p;
            e0 = m_last[k] * p + m_dwell[k];
            if (stop && m_cont[k] && m_end[k] < 0) begin
                // Stop seen in cycle t is pending from t+1; decision is made in the last dwell cycle.
                n        = m_t[k] + 2 - e0;
                kk       = (n <= 0) ? 0 : (n + fp - 1) / fp;
                m_end[k] = kk * fp + e0;
            end
            m_t[k]++;
            if (m_end[k] >= 0 && m_t[k] == m_end[k]) begin
                m_active[k] = 1'b0;
                m_fd[k]     = 1'b1;
            end
        end
    endtask

    task automatic expect_out(input int k, output logic [2:0] e_idx, output logic e_sv,
                              output logic e_bz, output logic e_fd);
        int p, fp, e0, o;
        if (!m_active[k]) begin
            e_idx = 3'd0;
            e_sv  = 1'b0;
            e_bz  = 1'b0;
            e_fd  = m_fd[k];
        end else begin
            p     = m_dwell[k] + BLANKS[k];
            fp    = (m_last[k] + 1) * p;
            e0    = m_last[k] * p + m_dwell[k];
            o     = m_t[k] % fp;
            e_idx = 3'(o / p);
            e_sv  = (o % p) < m_dwell[k];
            e_bz  = 1'b1;
            e_fd  = (m_t[k] >= e0) && (((m_t[k] - e0) % fp) == 0);
        end
    endtask

    task automatic tick();
        logic [2:0] e_idx;
        logic       e_sv, e_bz, e_fd;
        for (int k = 0; k < NM; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < NM; k++) begin
            expect_out(k, e_idx, e_sv, e_bz, e_fd);
            check($sformatf("%s b%0d xyz", phase, BLANKS[k]),
                  {5'd0, x_v[k], y_v[k], z_v[k]}, {5'd0, e_idx});
            check($sformatf("%s b%0d sel_valid", phase, BLANKS[k]), {7'd0, sv_v[k]}, {7'd0, e_sv});
            check($sformatf("%s b%0d busy", phase, BLANKS[k]), {7'd0, bz_v[k]}, {7'd0, e_bz});
            check($sformatf("%s b%0d frame_done", phase, BLANKS[k]), {7'd0, fd_v[k]}, {7'd0, e_fd});
            cnt_busy[k] += int'(bz_v[k]);
            cnt_fd[k]   += int'(fd_v[k]);
            cnt_sel[k]  += int'(sv_v[k]);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NM; k++) begin
            cnt_busy[k] = 0;
            cnt_fd[k]   = 0;
            cnt_sel[k]  = 0;
        end
    endtask

    task automatic go(input logic c, input int d, input int l);
        start    = 1'b1;
        cont     = c;
        dwell    = DW'(d);
        last_idx = 3'(l);
        tick();
        start    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; dwell = '0; last_idx = '0;
        for (int k = 0; k < NM; k++) begin
            m_active[k] = 1'b0; m_fd[k] = 1'b0; m_cont[k] = 1'b0;
            m_t[k] = 0; m_dwell[k] = 1; m_last[k] = 0; m_end[k] = -1;
        end
        phase = "reset";
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single frame, dwell 3, all eight channels.
        phase = "t1";
        clear_counts();
        go(1'b0, 3, 7);
        repeat (40) tick();
        check("t1 busy cycles b1", 8'(cnt_busy[0]), 8'd31);
        check("t1 sel cycles b1", 8'(cnt_sel[0]), 8'd24);
        check("t1 frame_done count b1", 8'(cnt_fd[0]), 8'd1);
        check("t1 busy cycles b2", 8'(cnt_busy[2]), 8'd38);

        // Continuous with a stop during the second frame at idx 1.
        phase = "t2";
        clear_counts();
        go(1'b1, 2, 2);
        repeat (12) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (20) tick();
        check("t2 busy cycles b1", 8'(cnt_busy[0]), 8'd17);
        check("t2 frame_done count b1", 8'(cnt_fd[0]), 8'd2);

        // Dwell 0 is treated as 1.
        phase = "t3";
        clear_counts();
        go(1'b0, 0, 0);
        repeat (4) tick();
        for (int k = 0; k < NM; k++) begin
            check($sformatf("t3 busy cycles b%0d", BLANKS[k]), 8'(cnt_busy[k]), 8'd1);
            check($sformatf("t3 frame_done count b%0d", BLANKS[k]), 8'(cnt_fd[k]), 8'd1);
        end

        // Start while busy must not disturb the latched configuration.
        phase = "t4";
        clear_counts();
        go(1'b0, 4, 3);
        repeat (5) tick();
        go(1'b1, 1, 7);
        repeat (25) tick();
        check("t4 busy cycles b1", 8'(cnt_busy[0]), 8'd19);
        check("t4 busy cycles b0", 8'(cnt_busy[1]), 8'd16);

        // Reset in the middle of a scan, then a clean restart.
        phase = "t5";
        go(1'b1, 2, 7);
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        go(1'b0, 2, 3);
        repeat (20) tick();

        // Dwell 1 across eight channels: gapless only in the unblanked build.
        phase = "t6";
        clear_counts();
        go(1'b0, 1, 7);
        repeat (20) tick();
        check("t6 sel cycles b0", 8'(cnt_sel[1]), 8'd8);
        check("t6 busy cycles b0", 8'(cnt_busy[1]), 8'd8);
        check("t6 busy cycles b1", 8'(cnt_busy[0]), 8'd15);

        // Start together with stop in IDLE: start wins, stop dropped.
        phase = "t7";
        start = 1'b1; stop = 1'b1; cont = 1'b1; dwell = DW'(1); last_idx = 3'd1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (12) tick();

        // Randomised traffic.
        phase = "rand";
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            start    = ($urandom_range(0, 7) == 0);
            cont     = 1'($urandom_range(0, 1));
            stop     = ($urandom_range(0, 19) == 0);
            dwell    = DW'($urandom_range(0, 4));
            last_idx = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (120) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
